stream_demux_1_to_p: RTL and testbench
======================================

// Module: stream_demux_1_to_p
//
// PURPOSE
// - Registered, handshaked 1-to-P demultiplexer, P = 2**N: routes one W-bit input
//   stream to the output channel selected by sel.
// - Optional broadcast mode copies one input word to every channel.
// - Each channel owns a one-entry output register, so a stalled consumer blocks only
//   itself, except in broadcast mode.
// - Sits between a single producer and P independent consumers, such as bus-port fan-out.
//
// PARAMETERS
// - N  2  select width; channel count P = 2**N (N >= 1)
// - W  8  data width per channel (W >= 1)
//
// PORTS
// - clock      in   1    single clock, rising edge
// - reset      in   1    asynchronous, active-high reset
// - in_valid   in   1    producer offers in_data/in_sel/in_bcast
// - in_ready   out  1    demux accepts this cycle (combinational)
// - in_data    in   W    word to route
// - in_sel     in   N    target channel p, natural binary
// - in_bcast   in   1    1: deliver to all P channels, in_sel ignored
// - out_valid  out  P    bit p: channel p holds a word
// - out_ready  in   P    bit p: consumer p takes the word this cycle
// - out_data   out  P*W  channel p data at [p*W +: W]
// - busy       out  1    |out_valid
//
// BEHAVIOUR
// - Reset (async, any time, mid-transfer included): out_valid = 0, out_data = 0, busy = 0.
//   Words held in channels are discarded. in_ready follows its equation and is 1 after reset.
// - free[p] = !out_valid[p] || out_ready[p]. A slot draining this cycle can reload in the same edge.
// - in_ready:
//   - in_bcast = 0: in_ready = free[in_sel]
//   - in_bcast = 1: in_ready = &free
// - Accept condition: in_valid && in_ready, sampled at the rising edge.
// - Load targets:
//   - Unicast: only channel in_sel loads in_data.
//   - Broadcast: every channel loads in_data.
// - Latency: a word accepted at edge k is visible with out_valid = 1 right after edge k
//   (1 cycle). No bypass path from in_data to out_data.
// - Per-channel update at each edge, in priority order:
//   1. load: out_valid[p] <= 1, out_data <= in_data
//   2. else if out_ready[p] && out_valid[p]: out_valid[p] <= 0, data held
//   3. else hold
// - Non-selected channels never change data. Unselected outputs stay 0 only via out_valid = 0.
// - out_ready[p] while out_valid[p] = 0 has no effect.
// - in_sel/in_data/in_bcast may change freely when in_valid = 0.
// - Under a stall with in_valid = 1, the producer holds all three stable.
// - Broadcast is all-or-nothing: no partial delivery. One stalled channel blocks the whole word.
// - No state machine beyond the P valid bits. Throughput is 1 word/cycle when consumers keep up.
//
// STRUCTURE
// - Package demux_pkg:
//   - Function chan_count(N) = 2**N.
//   - Localparam default widths.
// - Sub-module demux_chan_reg:
//   - One-entry valid/data register with load, drain and hold.
//   - Async active-high reset.
//   - Instantiated P times in a generate loop.
// - Top level:
//   - Decoder of in_sel into a one-hot load vector.
//   - OR with in_bcast replication, gated by accept.
//   - in_ready mux/AND and busy reduction.
//
// TESTING (N=2, W=8 unless stated)
// 1. Reset mid-stream:
//    - Stimulus: load ch2 with 0x5A, assert reset between edges.
//    - Response: out_valid = 0000 immediately, out_data = 0, busy = 0, in_ready = 1.
// 2. Unicast routing:
//    - Stimulus: sel = 0..3 with data 0x10..0x13, out_ready = 1111.
//    - Response: each word appears only on its channel one cycle after accept; other channels stay invalid.
// 3. Stall isolation:
//    - Stimulus: out_ready[1] = 0, send 0xA1 then 0xA2 to ch1, then 0xB0 to ch0.
//    - Response: 0xA1 held on ch1, in_ready = 0 for 0xA2, and 0xB0 still stalls behind it (in-order producer).
//    - Follow-up: release out_ready[1]; 0xA2 loads on the same edge 0xA1 drains.
// 4. Back-to-back full rate:
//    - Stimulus: 16 words to ch3, out_ready[3] = 1.
//    - Response: in_ready stays 1, 16 consecutive out_valid[3] cycles, data in order.
// 5. Broadcast:
//    - Stimulus: in_bcast = 1, data 0xC3, out_ready = 1011 with ch2 full.
//    - Response: in_ready = 0, nothing loads.
//    - Follow-up: when ch2 drains, all four channels show 0xC3 on the next cycle.
// 6. Parameter sweep:
//    - Stimulus: N = 1 and N = 3, W = 1 and W = 32, random valid/ready.
//    - Response: scoreboard shows no loss, duplication or reordering per channel.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-P stream demultiplexer.
package demux_pkg;

    localparam int unsigned DefaultN = 2;
    localparam int unsigned DefaultW = 8;

    function automatic int unsigned chan_count(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry output slot: load has priority over drain, otherwise the word is held.
module demux_chan_reg #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready && r_valid) begin
            // Drain clears only the valid flag; the stale word stays put.
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/stream_demux_1_to_p.sv
// Registered, handshaked 1-to-P demultiplexer with optional all-or-nothing broadcast.
module stream_demux_1_to_p
    import demux_pkg::*;
#(
    parameter  int unsigned N = DefaultN,
    parameter  int unsigned W = DefaultW,
    localparam int unsigned P = chan_count(N)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_in_valid,
    output logic           o_in_ready,
    input  logic [W-1:0]   i_in_data,
    input  logic [N-1:0]   i_in_sel,
    input  logic           i_in_bcast,
    output logic [P-1:0]   o_out_valid,
    input  logic [P-1:0]   i_out_ready,
    output logic [P*W-1:0] o_out_data,
    output logic           o_busy
);

    logic [P-1:0] w_free;
    logic [P-1:0] w_target;
    logic [P-1:0] w_load;
    logic         w_accept;

    // A slot draining this cycle counts as free so it can reload on the same edge.
    assign w_free = ~o_out_valid | i_out_ready;

    always_comb begin
        w_target = '0;
        if (i_in_bcast) begin
            w_target = '1;
        end else begin
            w_target[i_in_sel] = 1'b1;
        end
    end

    assign o_in_ready = i_in_bcast ? (&w_free) : w_free[i_in_sel];
    assign w_accept   = i_in_valid & o_in_ready;
    assign w_load     = {P{w_accept}} & w_target;
    assign o_busy     = |o_out_valid;

    for (genvar p = 0; p < P; p++) begin : g_chan
        demux_chan_reg #(
            .W(W)
        ) u_chan (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_load (w_load[p]),
            .i_data (i_in_data),
            .i_ready(i_out_ready[p]),
            .o_valid(o_out_valid[p]),
            .o_data (o_out_data[p*W +: W])
        );
    end

endmodule

// File: tb/tb_stream_demux_1_to_p.sv
// Bench for stream_demux_1_to_p: directed table/sequences at N=2,W=8 plus randomized sweeps.
module tb_stream_demux_1_to_p;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_bcast;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    stream_demux_1_to_p #(
        .N(2),
        .W(8)
    ) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_in_data  (in_data),
        .i_in_sel   (in_sel),
        .i_in_bcast (in_bcast),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_out_data (out_data),
        .o_busy     (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic b, input logic [7:0] d,
                         input logic [3:0] r);
        in_valid  = v;
        in_sel    = s;
        in_bcast  = b;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic        bc;
        logic [7:0]  d;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        logic [31:0] exp_od;
    } vec_t;

    vec_t tbl [9];

    // Randomized sweeps; each config has its own DUT, reset and capacity-1 queue model.
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int unsigned GN = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
        localparam int unsigned GW = (g == 0) ? 8 : ((g == 1) ? 1 : 32);
        localparam int unsigned GP = 1 << GN;

        logic            s_rst;
        logic            s_iv;
        logic            s_ir;
        logic [GW-1:0]   s_id;
        logic [GN-1:0]   s_is;
        logic            s_ib;
        logic [GP-1:0]   s_ov;
        logic [GP-1:0]   s_ordy;
        logic [GP*GW-1:0] s_od;
        logic            s_bz;
        bit              done = 1'b0;

        stream_demux_1_to_p #(
            .N(GN),
            .W(GW)
        ) u_sweep (
            .i_clk      (clk),
            .i_rst      (s_rst),
            .i_in_valid (s_iv),
            .o_in_ready (s_ir),
            .i_in_data  (s_id),
            .i_in_sel   (s_is),
            .i_in_bcast (s_ib),
            .o_out_valid(s_ov),
            .i_out_ready(s_ordy),
            .o_out_data (s_od),
            .o_busy     (s_bz)
        );

        initial begin
            logic [GW-1:0] sb_q [GP][$];
            logic [GP-1:0] exp_free;
            logic          exp_rdy;
            logic          acc;
            logic          any_held;
            s_rst  = 1'b1;
            s_iv   = 1'b0;
            s_id   = '0;
            s_is   = '0;
            s_ib   = 1'b0;
            s_ordy = '0;
            acc    = 1'b0;
            repeat (2) @(posedge clk);
            #1 s_rst = 1'b0;
            for (int cyc = 0; cyc < 2000; cyc++) begin
                // A stalled producer keeps its offer unchanged.
                if (!(s_iv && !acc)) begin
                    s_iv = ($urandom_range(0, 3) != 0);
                    s_ib = ($urandom_range(0, 7) == 0);
                    s_is = GN'($urandom_range(0, GP - 1));
                    s_id = GW'($urandom);
                end
                s_ordy = GP'($urandom);
                #1;
                any_held = 1'b0;
                for (int p = 0; p < GP; p++) begin
                    exp_free[p] = (sb_q[p].size() == 0) || s_ordy[p];
                    check("sweep out_valid", s_ov[p], sb_q[p].size() != 0);
                    if (sb_q[p].size() != 0) begin
                        any_held = 1'b1;
                        check("sweep out_data", s_od[p*GW +: GW], sb_q[p][0]);
                    end
                end
                exp_rdy = s_ib ? (&exp_free) : exp_free[s_is];
                check("sweep in_ready", s_ir, exp_rdy);
                check("sweep busy", s_bz, any_held);
                acc = s_iv && exp_rdy;
                @(posedge clk);
                #1;
                for (int p = 0; p < GP; p++) begin
                    if (sb_q[p].size() != 0 && s_ordy[p]) void'(sb_q[p].pop_front());
                    if (acc && (s_ib || int'(s_is) == p)) sb_q[p].push_back(s_id);
                end
            end
            done = 1'b1;
        end
    end

    initial begin
        tbl[0] = '{1'b1, 2'd0, 1'b0, 8'h10, 4'b1111, 1'b1, 4'b0001, 32'h0000_0010};
        tbl[1] = '{1'b1, 2'd1, 1'b0, 8'h11, 4'b1111, 1'b1, 4'b0010, 32'h0000_1110};
        tbl[2] = '{1'b1, 2'd2, 1'b0, 8'h12, 4'b1111, 1'b1, 4'b0100, 32'h0012_1110};
        tbl[3] = '{1'b1, 2'd3, 1'b0, 8'h13, 4'b1111, 1'b1, 4'b1000, 32'h1312_1110};
        tbl[4] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h1312_1110};
        tbl[5] = '{1'b1, 2'd2, 1'b0, 8'h77, 4'b1011, 1'b1, 4'b0100, 32'h1377_1110};
        tbl[6] = '{1'b1, 2'd0, 1'b1, 8'hC3, 4'b1011, 1'b0, 4'b0100, 32'h1377_1110};
        tbl[7] = '{1'b1, 2'd0, 1'b1, 8'hC3, 4'b1111, 1'b1, 4'b1111, 32'hC3C3_C3C3};
        tbl[8] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'hC3C3_C3C3};

        rst = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 4'b0000);
        check("reset out_data", out_data, 32'h0);
        check("reset busy", busy, 1'b0);
        check("reset in_ready", in_ready, 1'b1);
        rst = 1'b0;

        // Reset mid-stream: load ch2 then assert reset between edges.
        drive(1'b1, 2'd2, 1'b0, 8'h5A, 4'b0000);
        tick();
        check("ch2 load valid", out_valid, 4'b0100);
        check("ch2 load data", out_data[23:16], 8'h5A);
        drive(1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
        #2 rst = 1'b1;
        #1;
        check("midreset out_valid", out_valid, 4'b0000);
        check("midreset out_data", out_data, 32'h0);
        check("midreset busy", busy, 1'b0);
        check("midreset in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Unicast routing and broadcast vectors.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].bc, tbl[i].d, tbl[i].ordy);
            #1;
            check($sformatf("tbl[%0d] in_ready", i), in_ready, tbl[i].exp_rdy);
            tick();
            check($sformatf("tbl[%0d] out_valid", i), out_valid, tbl[i].exp_ov);
            check($sformatf("tbl[%0d] out_data", i), out_data, tbl[i].exp_od);
            check($sformatf("tbl[%0d] busy", i), busy, |tbl[i].exp_ov);
        end

        // Stall isolation on ch1.
        drive(1'b1, 2'd1, 1'b0, 8'hA1, 4'b1101);
        #1 check("stall A1 in_ready", in_ready, 1'b1);
        tick();
        check("stall A1 valid", out_valid, 4'b0010);
        check("stall A1 data", out_data[15:8], 8'hA1);
        drive(1'b1, 2'd1, 1'b0, 8'hA2, 4'b1101);
        #1 check("stall A2 in_ready", in_ready, 1'b0);
        tick();
        check("stall hold valid", out_valid, 4'b0010);
        check("stall hold data", out_data[15:8], 8'hA1);
        check("stall B0 blocked", in_ready, 1'b0);
        tick();
        check("stall hold2 valid", out_valid, 4'b0010);
        out_ready = 4'b1111;
        #1 check("release in_ready", in_ready, 1'b1);
        tick();
        check("reload A2 valid", out_valid, 4'b0010);
        check("reload A2 data", out_data[15:8], 8'hA2);
        drive(1'b1, 2'd0, 1'b0, 8'hB0, 4'b1111);
        #1 check("B0 in_ready", in_ready, 1'b1);
        tick();
        check("B0 valid", out_valid, 4'b0001);
        check("B0 data", out_data[7:0], 8'hB0);
        drive(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
        tick();
        check("stall drained", out_valid, 4'b0000);

        // Back-to-back full rate on ch3.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'd3, 1'b0, 8'h40 + 8'(i), 4'b1000);
            #1 check($sformatf("burst[%0d] in_ready", i), in_ready, 1'b1);
            tick();
            check($sformatf("burst[%0d] valid", i), out_valid, 4'b1000);
            check($sformatf("burst[%0d] data", i), out_data[31:24], 8'h40 + 8'(i));
        end
        drive(1'b0, 2'd0, 1'b0, 8'h00, 4'b1000);
        tick();
        check("burst drained", out_valid, 4'b0000);

        begin
            int waited = 0;
            while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && waited < 20000) begin
                @(posedge clk);
                waited++;
            end
            vectors++;
            if (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done)) begin
                miscompares++;
                $display("FAIL sweep timeout: got not done expected done after %0d cycles", waited);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
